// File: rtl/avm_block_reader_pkg.sv
// Shared types and constants for the Avalon-MM block reader.
package avm_block_reader_pkg;

  localparam int DATA_W = 32;
  // Wide enough for READ_LATENCY-1 with READ_LATENCY up to 4.
  localparam int LAT_W = 2;
  localparam logic [3:0] BYTEENABLE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/avm_block_reader.sv
// Avalon-MM initiator that streams a block of consecutive words out of an on-chip RAM.
// Optional running checksum output is enabled by defining AVM_BLOCK_READER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | no block in progress, waiting for start
// REQ   | read request on the bus, held while the slave stalls
// WAIT  | request accepted, counting down the slave read latency
// HOLD  | fetched word presented downstream, waiting for out_ready
module avm_block_reader
  import avm_block_reader_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int CNT_W        = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef AVM_BLOCK_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [DATA_W-1:0] out_data_q;
  logic              done_q;

  logic start_ok;
  logic start_blk;
  logic start_empty;
  logic req_accept;
  logic capture;
  logic accept;
  logic last_word;

  // Abort outranks start even in IDLE, so a coincident start is dropped.
  assign start_ok    = (state_q == IDLE) && start && !abort;
  assign start_blk   = start_ok && (word_count != '0);
  assign start_empty = start_ok && (word_count == '0);
  assign req_accept  = (state_q == REQ)  && !abort && !avm_waitrequest;
  assign capture     = (state_q == WAIT) && !abort && (lat_cnt_q == '0);
  assign accept      = (state_q == HOLD) && !abort && out_ready;
  assign last_word   = (remaining_q == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_blk) state_d = REQ;
        REQ:  if (!avm_waitrequest) state_d = WAIT;
        WAIT: if (lat_cnt_q == '0) state_d = HOLD;
        HOLD: begin
          if (out_ready) state_d = last_word ? IDLE : REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    avm_read       = 1'b0;
    avm_chipselect = 1'b0;
    avm_byteenable = '0;
    out_valid      = 1'b0;
    busy           = 1'b0;
    if (state_q == REQ) begin
      avm_read       = 1'b1;
      avm_chipselect = 1'b1;
      avm_byteenable = BYTEENABLE_ALL;
    end
    if (state_q == HOLD) out_valid = 1'b1;
    if (state_q != IDLE) busy = 1'b1;
  end

  assign avm_address = addr_q;
  assign out_data    = out_data_q;
  assign done        = done_q;

  // Address wraps naturally at 2^ADDR_W through the fixed register width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      lat_cnt_q   <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= start_empty || (accept && last_word);
      if (start_blk) begin
        addr_q      <= base_addr;
        remaining_q <= word_count;
      end
      if (req_accept) begin
        lat_cnt_q <= LAT_W'(READ_LATENCY - 1);
      end else if ((state_q == WAIT) && !abort && (lat_cnt_q != '0)) begin
        lat_cnt_q <= lat_cnt_q - LAT_W'(1);
      end
      if (capture) begin
        out_data_q <= avm_readdata;
      end
      if (accept) begin
        addr_q      <= addr_q + ADDR_W'(1);
        remaining_q <= remaining_q - CNT_W'(1);
      end
    end
  end

`ifdef AVM_BLOCK_READER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  // Left untouched by abort and done so the last (partial) sum stays readable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (start_ok) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + out_data_q;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_avm_block_reader.sv
// Self-checking bench for avm_block_reader: behavioural RAM slave, randomized blocks,
// directed stall/backpressure/wrap/abort/reset scenarios.
module tb_avm_block_reader;

  localparam int ADDR_W = 2;
  localparam int CNT_W  = 8;
  localparam int LAT    = 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;
`ifdef AVM_BLOCK_READER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  avm_block_reader #(
    .ADDR_W(ADDR_W),
    .CNT_W(CNT_W),
    .READ_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .word_count(word_count),
    .abort(abort),
    .busy(busy),
    .done(done),
    .avm_address(avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_read(avm_read),
    .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef AVM_BLOCK_READER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural RAM slave: fixed latency, junk on the bus when nothing returns.
  logic [31:0]       mem [DEPTH];
  logic              acc_n = 1'b0;
  logic [ADDR_W-1:0] acc_addr_n = '0;
  logic              pv [LAT];
  logic [31:0]       pd [LAT];

  always @(posedge clk) begin
    pv[0] <= acc_n;
    pd[0] <= mem[acc_addr_n];
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end

  assign avm_readdata = (pv[LAT-1] === 1'b1) ? pd[LAT-1] : 32'hDEAD_BEEF;

  // Passive recorder of bus and stream events.
  int                cyc = 0;
  logic [ADDR_W-1:0] rd_q[$];
  int                rd_cyc[$];
  logic [31:0]       word_q[$];
  int                done_cnt = 0;
  int                done_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    acc_n      <= avm_read && !avm_waitrequest;
    acc_addr_n <= avm_address;
    if (avm_read && !avm_waitrequest) begin
      rd_q.push_back(avm_address);
      rd_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) word_q.push_back(out_data);
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (busy || out_valid) done_bad <= done_bad + 1;
    end
  end

  // Stimulus configuration shared by the scenario tasks.
  bit                cfg_ready_rand = 0;
  bit                cfg_wr_rand = 0;
  bit                cfg_mid_start = 0;
  logic [ADDR_W-1:0] stall_addr = '0;
  int                stall_left = 0;
  logic [31:0]       hold_word = '0;
  int                hold_left = 0;

  logic              p_read, p_wr, p_valid, p_ready;
  logic [ADDR_W-1:0] p_addr;
  logic [31:0]       p_data;

  // Called #1 after each rising edge: protocol checks against the previous cycle, then drive.
  task automatic drive_cycle();
    if (p_read && p_wr) begin
      tests_run++;
      if (avm_read !== 1'b1 || avm_address !== p_addr) begin
        tests_failed++;
        $display("FAIL stall_stable: read=%0b addr=%0d, required read=1 addr=%0d", avm_read, avm_address, p_addr);
      end
    end
    if (p_valid && !p_ready) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== p_data) begin
        tests_failed++;
        $display("FAIL hold_stable: valid=%0b data=%h, required valid=1 data=%h", out_valid, out_data, p_data);
      end
    end
    if (avm_read || out_valid) begin
      tests_run++;
      if (avm_read && out_valid) begin
        tests_failed++;
        $display("FAIL read_while_valid: read=%0b valid=%0b, required not both", avm_read, out_valid);
      end
    end
    if (avm_read) begin
      tests_run++;
      if (avm_chipselect !== 1'b1 || avm_byteenable !== 4'b1111) begin
        tests_failed++;
        $display("FAIL bus_qualifiers: cs=%0b be=%b, required cs=1 be=1111", avm_chipselect, avm_byteenable);
      end
    end
    if (stall_left > 0 && avm_read && avm_address == stall_addr) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end else begin
      avm_waitrequest = cfg_wr_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    if (hold_left > 0 && out_valid && out_data == hold_word) begin
      out_ready = 1'b0;
      hold_left--;
    end else begin
      out_ready = cfg_ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    p_read  = avm_read;
    p_wr    = avm_waitrequest;
    p_addr  = avm_address;
    p_valid = out_valid;
    p_ready = out_ready;
    p_data  = out_data;
  endtask

  task automatic run_block(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt,
                           input string name, output int done_at);
    int          rd0, wd0, dn0, bd0, budget, n, nw;
    bit          seen;
    logic [31:0] sum;
    logic [ADDR_W-1:0] ea;
    rd0 = rd_q.size();
    wd0 = word_q.size();
    dn0 = done_cnt;
    bd0 = done_bad;
    done_at = -1;
    seen = 0;
    budget = 60 + int'(cnt) * 40;
    p_read = 0;
    p_valid = 0;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    word_count = cnt;
    out_ready = 1'b1;
    avm_waitrequest = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cfg_mid_start && c == 4) begin
        start = 1'b1;
        base_addr = base + 2'd1;
        word_count = cnt + 8'd3;
      end
      drive_cycle();
      if (done) begin
        seen = 1;
        done_at = c;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s_timeout: no done within %0d cycles, required done", name, budget);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_after_done: done=%0b busy=%0b, required 0 0", name, done, busy);
    end
    n = rd_q.size() - rd0;
    nw = word_q.size() - wd0;
    tests_run++;
    if (n != int'(cnt) || nw != int'(cnt)) begin
      tests_failed++;
      $display("FAIL %s_counts: reads=%0d words=%0d, required %0d", name, n, nw, cnt);
    end
    sum = '0;
    for (int i = 0; i < int'(cnt); i++) begin
      ea = ADDR_W'((int'(base) + i) % DEPTH);
      sum += mem[ea];
      if (i < n) begin
        tests_run++;
        if (rd_q[rd0+i] !== ea) begin
          tests_failed++;
          $display("FAIL %s_addr[%0d]: got %0d, required %0d", name, i, rd_q[rd0+i], ea);
        end
      end
      if (i < nw) begin
        tests_run++;
        if (word_q[wd0+i] !== mem[ea]) begin
          tests_failed++;
          $display("FAIL %s_word[%0d]: got %h, required %h", name, i, word_q[wd0+i], mem[ea]);
        end
      end
    end
    tests_run++;
    if (done_cnt - dn0 != 1 || done_bad != bd0) begin
      tests_failed++;
      $display("FAIL %s_done: pulses=%0d bad=%0d, required 1 0", name, done_cnt - dn0, done_bad - bd0);
    end
`ifdef AVM_BLOCK_READER_CHECKSUM_EN
    tests_run++;
    if (checksum !== sum) begin
      tests_failed++;
      $display("FAIL %s_checksum: got %h, required %h", name, checksum, sum);
    end
`endif
  endtask

  task automatic load_table();
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, avm_read, avm_chipselect, out_valid} !== 5'b0 || avm_byteenable !== 4'b0 ||
        avm_address !== '0 || out_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%0b done=%0b read=%0b cs=%0b valid=%0b be=%b addr=%0d data=%h, required all 0",
               busy, done, avm_read, avm_chipselect, out_valid, avm_byteenable, avm_address, out_data);
    end
`ifdef AVM_BLOCK_READER_CHECKSUM_EN
    tests_run++;
    if (checksum !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_checksum: got %h, required 0", checksum);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int rd0, da;
    load_table();
    rd0 = rd_q.size();
    run_block(2'd0, 8'd4, "basic", da);
    tests_run++;
    if (da != 4 * (2 + LAT)) begin
      tests_failed++;
      $display("FAIL basic_throughput: done after %0d cycles, required %0d", da, 4 * (2 + LAT));
    end
    for (int i = 1; i < 4; i++) begin
      if (rd0 + i < rd_cyc.size()) begin
        tests_run++;
        if (rd_cyc[rd0+i] - rd_cyc[rd0+i-1] != 2 + LAT) begin
          tests_failed++;
          $display("FAIL basic_spacing[%0d]: %0d cycles, required %0d", i, rd_cyc[rd0+i] - rd_cyc[rd0+i-1], 2 + LAT);
        end
      end
    end
`ifdef AVM_BLOCK_READER_CHECKSUM_EN
    tests_run++;
    if (checksum !== 32'hAA) begin
      tests_failed++;
      $display("FAIL basic_checksum_aa: got %h, required 000000aa", checksum);
    end
`endif
  endtask

  task automatic test_stall();
    int da;
    load_table();
    stall_addr = 2'd1;
    stall_left = 3;
    run_block(2'd0, 8'd4, "stall", da);
    tests_run++;
    if (stall_left != 0) begin
      tests_failed++;
      $display("FAIL stall_applied: %0d stall cycles unused, required 0", stall_left);
    end
    stall_left = 0;
  endtask

  task automatic test_backpressure();
    int da;
    load_table();
    hold_word = 32'h22;
    hold_left = 5;
    run_block(2'd0, 8'd4, "hold", da);
    tests_run++;
    if (hold_left != 0) begin
      tests_failed++;
      $display("FAIL hold_applied: %0d hold cycles unused, required 0", hold_left);
    end
    hold_left = 0;
  endtask

  task automatic test_wrap();
    int da;
    load_table();
    run_block(2'd3, 8'd3, "wrap3", da);
    run_block(2'd3, 8'd2, "wrap2", da);
  endtask

  task automatic test_zero_count();
    int da;
    load_table();
    run_block(2'd1, 8'd0, "zero", da);
    tests_run++;
    if (da != 0) begin
      tests_failed++;
      $display("FAIL zero_done_latency: done at cycle %0d, required 0", da);
    end
  endtask

  task automatic test_start_while_busy();
    int da;
    load_table();
    cfg_mid_start = 1;
    run_block(2'd1, 8'd4, "busy_start", da);
    cfg_mid_start = 0;
  endtask

  task automatic test_abort();
    int  rd0, wd0, dn0, da;
    bit  found;
    load_table();
    rd0 = rd_q.size();
    wd0 = word_q.size();
    dn0 = done_cnt;
    found = 0;
    p_read = 0;
    p_valid = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 2'd0; word_count = 8'd4;
    for (int c = 0; c < 60 && !found; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      drive_cycle();
      if (rd_q.size() - rd0 == 2 && !avm_read && !out_valid && busy) found = 1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL abort_reach_wait: second read never pending, required WAIT of word 2");
    end
    abort = 1'b1;
    start = 1'b1; base_addr = 2'd3; word_count = 8'd2;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || avm_read !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: busy=%0b valid=%0b read=%0b done=%0b, required 0 0 0 0", busy, out_valid, avm_read, done);
    end
`ifdef AVM_BLOCK_READER_CHECKSUM_EN
    tests_run++;
    if (checksum !== mem[0]) begin
      tests_failed++;
      $display("FAIL abort_partial_sum: got %h, required %h", checksum, mem[0]);
    end
`endif
    tests_run++;
    if (done_cnt != dn0) begin
      tests_failed++;
      $display("FAIL abort_no_done: %0d pulses, required 0", done_cnt - dn0);
    end
    tests_run++;
    if (word_q.size() - wd0 != 1 || rd_q.size() - rd0 != 2) begin
      tests_failed++;
      $display("FAIL abort_partial: words=%0d reads=%0d, required 1 2", word_q.size() - wd0, rd_q.size() - rd0);
    end
    run_block(2'd2, 8'd1, "after_abort", da);
  endtask

  task automatic test_reset_midop();
    int  rd0, wd0, dn0;
    bit  found, bad;
    load_table();
    rd0 = rd_q.size();
    wd0 = word_q.size();
    dn0 = done_cnt;
    found = 0;
    bad = 0;
    p_read = 0;
    p_valid = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 2'd0; word_count = 8'd4;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      drive_cycle();
      if (rd_q.size() > rd0) found = 1;
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (!found || busy !== 1'b0 || out_valid !== 1'b0 || avm_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_midop_clear: found=%0b busy=%0b valid=%0b read=%0b, required 1 0 0 0", found, busy, out_valid, avm_read);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy || avm_read) bad = 1;
    end
    tests_run++;
    if (bad || word_q.size() != wd0 || rd_q.size() != rd0 + 1 || done_cnt != dn0) begin
      tests_failed++;
      $display("FAIL reset_stale_ignored: activity=%0b words=%0d reads=%0d dones=%0d, required 0 0 1 0",
               bad, word_q.size() - wd0, rd_q.size() - rd0, done_cnt - dn0);
    end
  endtask

  task automatic test_random();
    int da;
    logic [ADDR_W-1:0] b;
    logic [CNT_W-1:0]  n;
    cfg_ready_rand = 1;
    cfg_wr_rand = 1;
    for (int k = 0; k < 20; k++) begin
      for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
      b = ADDR_W'($urandom_range(0, DEPTH - 1));
      n = CNT_W'($urandom_range(1, 9));
      run_block(b, n, "random", da);
    end
    cfg_ready_rand = 0;
    cfg_wr_rand = 0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    abort = 1'b0;
    avm_waitrequest = 1'b0;
    out_ready = 1'b0;
    p_read = 0; p_wr = 0; p_valid = 0; p_ready = 0; p_addr = '0; p_data = '0;
    load_table();
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_wrap();
    test_zero_count();
    test_start_while_busy();
    test_abort();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
